regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/regfile_mp.sv | 122 ++++++++++++
 tb/tb_regfile_mp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file with scoreboard.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_ADDRESS_WIDTH = 5;
    localparam int unsigned DEF_NUM_REGS      = 32;
    localparam int unsigned DEF_NUM_RD_PORTS  = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at issue, cleared at
// writeback or by the sweep, with a combinational lookup per read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
    parameter int unsigned NUM_RD_PORTS  = DEF_NUM_RD_PORTS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  set_en,
    input  logic [ADDRESS_WIDTH-1:0]              set_dest,
    input  logic                                  clr_en,
    input  logic [ADDRESS_WIDTH-1:0]              clr_dest,
    input  logic                                  sweep_en,
    input  logic [ADDRESS_WIDTH-1:0]              sweep_idx,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD_PORTS-1:0]               rd_busy
);

    localparam int unsigned AW = ADDRESS_WIDTH;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [AW-1:0]       addr;

    // Set is applied after the writeback clear so a same-cycle re-issue stays pending.
    always_comb begin
        busy_d    = busy_q;
        busy_d[0] = 1'b0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (sweep_en && sweep_idx == AW'(i)) begin
                busy_d[i] = 1'b0;
            end else begin
                if (clr_en && clr_dest == AW'(i)) busy_d[i] = 1'b0;
                if (set_en && set_dest == AW'(i)) busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    always_comb begin
        rd_busy = '0;
        addr    = '0;
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            addr = rd_addr[k*AW +: AW];
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (addr == AW'(i)) rd_busy[k] = busy_q[i];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, pending-write
// scoreboard and a sweep clear. Define REGFILE_MP_BYPASS_EN for write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = DEF_NUM_REGS,
    parameter int unsigned NUM_RD_PORTS  = DEF_NUM_RD_PORTS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rg_wrt_en,
    input  logic [ADDRESS_WIDTH-1:0]              rg_wrt_dest,
    input  logic [DATA_WIDTH-1:0]                 rg_wrt_data,
    input  logic [NUM_RD_PORTS*ADDRESS_WIDTH-1:0] rg_rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]    rg_rd_data,
    output logic [NUM_RD_PORTS-1:0]               rg_rd_busy,
    input  logic                                  sb_set_en,
    input  logic [ADDRESS_WIDTH-1:0]              sb_set_dest,
    input  logic                                  clr_req,
    output logic                                  clr_busy
);

    localparam int unsigned   AW       = ADDRESS_WIDTH;
    localparam int unsigned   DW       = DATA_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW:0]   REG_LIM  = (AW+1)'(NUM_REGS);

    rf_state_e             state_q;
    logic [AW-1:0]         cnt_q;
    logic [DW-1:0]         regs_q [NUM_REGS];
    logic                  idle;
    logic                  sweep_en;
    logic                  wr_hit;
    logic                  set_hit;
    logic [NUM_RD_PORTS-1:0] sb_busy;
    logic [AW-1:0]         rd_addr;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < REG_LIM);
    endfunction

    assign idle     = (state_q == IDLE);
    assign sweep_en = (state_q == CLEAR);
    assign clr_busy = sweep_en;
    assign wr_hit   = idle && rg_wrt_en && addr_ok(rg_wrt_dest);
    assign set_hit  = idle && sb_set_en && addr_ok(sb_set_dest);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q <= CLEAR;
                        cnt_q   <= AW'(1);
                    end
                end
                CLEAR: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + AW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Entry 0 is only ever reset, so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (sweep_en && cnt_q == AW'(i))          regs_q[i] <= '0;
                else if (wr_hit && rg_wrt_dest == AW'(i)) regs_q[i] <= rg_wrt_data;
            end
        end
    end

    regfile_scoreboard #(
        .ADDRESS_WIDTH (AW),
        .NUM_REGS      (NUM_REGS),
        .NUM_RD_PORTS  (NUM_RD_PORTS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_hit),
        .set_dest  (sb_set_dest),
        .clr_en    (wr_hit),
        .clr_dest  (rg_wrt_dest),
        .sweep_en  (sweep_en),
        .sweep_idx (cnt_q),
        .rd_addr   (rg_rd_addr),
        .rd_busy   (sb_busy)
    );

    always_comb begin
        rg_rd_data = '0;
        rg_rd_busy = sb_busy;
        rd_addr    = '0;
        for (int unsigned k = 0; k < NUM_RD_PORTS; k++) begin
            rd_addr = rg_rd_addr[k*AW +: AW];
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (rd_addr == AW'(i)) rg_rd_data[k*DW +: DW] = regs_q[i];
            end
`ifdef REGFILE_MP_BYPASS_EN
            if (wr_hit && rd_addr == rg_wrt_dest) begin
                rg_rd_data[k*DW +: DW] = rg_wrt_data;
                rg_rd_busy[k]          = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, sweep/reset sequences, and a
// randomized run against an array-based reference model.
module tb_regfile_mp;

    localparam int unsigned NREGS = 32;
`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [9:0]  rg_rd_addr;
    logic [63:0] rg_rd_data;
    logic [1:0]  rg_rd_busy;
    logic        sb_set_en;
    logic [4:0]  sb_set_dest;
    logic        clr_req;
    logic        clr_busy;

    regfile_mp #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (5),
        .NUM_REGS      (NREGS),
        .NUM_RD_PORTS  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_dest (rg_wrt_dest),
        .rg_wrt_data (rg_wrt_data),
        .rg_rd_addr  (rg_rd_addr),
        .rg_rd_data  (rg_rd_data),
        .rg_rd_busy  (rg_rd_busy),
        .sb_set_en   (sb_set_en),
        .sb_set_dest (sb_set_dest),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: architectural register contents, pending flags, sweep progress.
    logic [31:0] m_mem  [NREGS];
    bit          m_busy [NREGS];
    bit          m_clr;
    int unsigned m_idx;

    typedef struct {
        logic        wr_en;
        logic [4:0]  wr_dest;
        logic [31:0] wr_data;
        logic        set_en;
        logic [4:0]  set_dest;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic        eb0;
        logic [31:0] ed1;
        logic        eb1;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr = 1'b0;
        m_idx = 0;
    endtask

    task automatic exp_rd(input logic [4:0] a, output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (a != 0 && int'(a) < NREGS) begin
            d = m_mem[a];
            b = m_busy[a];
            if (BYP && !m_clr && rg_wrt_en && rg_wrt_dest == a) begin
                d = rg_wrt_data;
                b = 1'b0;
            end
        end
    endtask

    // Applies the effect of one rising edge given the inputs currently driven.
    task automatic model_edge();
        if (m_clr) begin
            m_mem[m_idx]  = '0;
            m_busy[m_idx] = 1'b0;
            if (m_idx == NREGS - 1) m_clr = 1'b0;
            else                    m_idx++;
        end else begin
            if (rg_wrt_en && rg_wrt_dest != 0 && int'(rg_wrt_dest) < NREGS) begin
                m_mem[rg_wrt_dest]  = rg_wrt_data;
                m_busy[rg_wrt_dest] = 1'b0;
            end
            if (sb_set_en && sb_set_dest != 0 && int'(sb_set_dest) < NREGS)
                m_busy[sb_set_dest] = 1'b1;
            if (clr_req) begin
                m_clr = 1'b1;
                m_idx = 1;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] d;
        logic        b;
        exp_rd(rg_rd_addr[4:0], d, b);
        chk("rd_data0", rg_rd_data[31:0], d);
        chk("rd_busy0", rg_rd_busy[0], b);
        exp_rd(rg_rd_addr[9:5], d, b);
        chk("rd_data1", rg_rd_data[63:32], d);
        chk("rd_busy1", rg_rd_busy[1], b);
        chk("clr_busy", clr_busy, m_clr);
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rg_wrt_en = 1'b0; rg_wrt_dest = '0; rg_wrt_data = '0;
        sb_set_en = 1'b0; sb_set_dest = '0; clr_req = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREGS; i++) begin
            idle_inputs();
            rg_wrt_en = 1'b1; rg_wrt_dest = 5'(i); rg_wrt_data = 32'h0101_0101 * i + 32'h77;
            sb_set_en = (i % 3 == 0); sb_set_dest = 5'(i + 1);
            rg_rd_addr = {5'(i), 5'(i - 1)};
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        int  cyc;
        bit  done;

        tbl[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0, BYP ? 32'hDEAD_BEEF : 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h0, 1'b1, 32'h0, 1'b1};
        tbl[6]  = tbl[5];
        tbl[7]  = tbl[5];
        tbl[8]  = '{1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 5'd7, 5'd5, BYP ? 32'hA5 : 32'h0, !BYP, 32'hDEAD_BEEF, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA5, 1'b0, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 5'd9, 5'd9, BYP ? 32'h11 : 32'h0, 1'b0, BYP ? 32'h11 : 32'h0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd9, 32'h11, 1'b1, 32'h11, 1'b1};

        // Reset state
        rst_n = 1'b0;
        idle_inputs();
        rg_rd_addr = {5'd31, 5'd5};
        model_reset();
        #12;
        chk("reset_data", rg_rd_data, 64'h0);
        chk("reset_busy", rg_rd_busy, 2'b00);
        chk("reset_clr_busy", clr_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int r = 0; r < 12; r++) begin
            rg_wrt_en = tbl[r].wr_en; rg_wrt_dest = tbl[r].wr_dest; rg_wrt_data = tbl[r].wr_data;
            sb_set_en = tbl[r].set_en; sb_set_dest = tbl[r].set_dest; clr_req = 1'b0;
            rg_rd_addr = {tbl[r].ra1, tbl[r].ra0};
            @(negedge clk);
            chk($sformatf("vec%0d_d0", r), rg_rd_data[31:0], tbl[r].ed0);
            chk($sformatf("vec%0d_b0", r), rg_rd_busy[0], tbl[r].eb0);
            chk($sformatf("vec%0d_d1", r), rg_rd_data[63:32], tbl[r].ed1);
            chk($sformatf("vec%0d_b1", r), rg_rd_busy[1], tbl[r].eb1);
            chk($sformatf("vec%0d_clr", r), clr_busy, 1'b0);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Full sweep with a write, a set and a re-request dropped mid-sweep
        fill_all();
        clr_req = 1'b1;
        rg_rd_addr = {5'd3, 5'd31};
        tick();
        clr_req = 1'b0;
        cyc  = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            idle_inputs();
            if (cyc == 4) begin
                rg_wrt_en = 1'b1; rg_wrt_dest = 5'd3; rg_wrt_data = 32'hFFFF;
                sb_set_en = 1'b1; sb_set_dest = 5'd4; clr_req = 1'b1;
            end
            @(negedge clk);
            check_model();
            if (clr_busy) cyc++;
            else          done = 1'b1;
            @(posedge clk);
            model_edge();
            #1;
        end
        idle_inputs();
        chk("sweep_done", done, 1'b1);
        chk("sweep_len", cyc, 31);
        for (int a = 0; a < NREGS; a++) begin
            rg_rd_addr = {5'(31 - a), 5'(a)};
            @(negedge clk);
            chk($sformatf("post_sweep_x%0d", a), rg_rd_data, 64'h0);
            chk($sformatf("post_sweep_busy_x%0d", a), rg_rd_busy, 2'b00);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Reset asserted during sweep cycle 10
        fill_all();
        clr_req = 1'b1;
        rg_rd_addr = {5'd20, 5'd31};
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midsweep_rst_clr_busy", clr_busy, 1'b0);
        chk("midsweep_rst_data", rg_rd_data, 64'h0);
        chk("midsweep_rst_busy", rg_rd_busy, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 5; c++) tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] a0, a1;
            rg_wrt_en   = $urandom_range(0, 1);
            rg_wrt_dest = 5'($urandom);
            rg_wrt_data = $urandom;
            sb_set_en   = ($urandom_range(0, 2) == 0);
            sb_set_dest = ($urandom_range(0, 3) == 0) ? rg_wrt_dest : 5'($urandom);
            clr_req     = ($urandom_range(0, 149) == 0);
            a0 = ($urandom_range(0, 3) == 0) ? rg_wrt_dest : 5'($urandom);
            a1 = ($urandom_range(0, 3) == 0) ? sb_set_dest : 5'($urandom);
            rg_rd_addr = {a1, a0};
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
